// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-port SRAM arbiter between instruction fetch (I) and load/store (D) requesters
module sram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic [3:0]        d_w_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic [3:0]        mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt,
    input  logic              cnt_clr
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_I    = 2'd1,
        PEND_D    = 2'd2
    } pend_t;

    pend_t             r_rd_pend_q;
    pend_t             w_rd_pend_d;
    logic [SW-1:0]     r_starve_cnt;
    logic [CNT_W-1:0]  r_conflict_cnt;
    logic              w_i_win;
    logic              w_i_gnt;
    logic              w_d_gnt;
    logic              w_conflict;

    // I wins a conflict only once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        w_conflict = i_req & d_req;
        w_i_win    = i_req & (~d_req | (r_starve_cnt >= LIMIT));
        w_i_gnt    = w_i_win & ~rst;
        w_d_gnt    = d_req & ~w_i_win & ~rst;
    end

    always_comb begin
        mem_w_en  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_i_gnt) begin
            mem_addr = i_addr;
        end else if (w_d_gnt) begin
            mem_w_en  = d_w_en;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        w_rd_pend_d = PEND_NONE;
        if (w_i_gnt) begin
            w_rd_pend_d = PEND_I;
        end else if (w_d_gnt && (d_w_en == 4'b0000)) begin
            w_rd_pend_d = PEND_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend_q <= PEND_NONE;
        end else begin
            r_rd_pend_q <= w_rd_pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!i_req || w_i_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    // Clear wins over a same-cycle conflict; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (cnt_clr) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        i_gnt        = w_i_gnt;
        d_gnt        = w_d_gnt;
        i_stall      = i_req & ~w_i_gnt;
        d_stall      = d_req & ~w_d_gnt;
        i_rvalid     = (r_rd_pend_q == PEND_I);
        d_rvalid     = (r_rd_pend_q == PEND_D);
        i_rdata      = i_rvalid ? mem_rdata : '0;
        d_rdata      = d_rvalid ? mem_rdata : '0;
        conflict_cnt = r_conflict_cnt;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - vector-table bench for sram_port_arbiter with a behavioural SRAM
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt, i_rvalid, i_stall;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_w_en;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid, d_stall;
    logic [31:0] d_rdata;
    logic [3:0]  mem_w_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;
    logic        cnt_clr;

    logic        s_i_gnt, s_i_rvalid, s_i_stall, s_d_gnt, s_d_rvalid, s_d_stall;
    logic [31:0] s_i_rdata, s_d_rdata, s_mem_wdata;
    logic [3:0]  s_mem_w_en;
    logic [15:0] s_mem_addr;
    logic [1:0]  s_conflict_cnt;

    logic [31:0] sram [0:255];
    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_w_en(d_w_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt), .cnt_clr(cnt_clr)
    );

    sram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata), .i_stall(s_i_stall),
        .d_req(d_req), .d_w_en(d_w_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata), .d_stall(s_d_stall),
        .mem_w_en(s_mem_w_en), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(s_conflict_cnt), .cnt_clr(cnt_clr)
    );

    // Word-indexed synchronous SRAM: read-before-write, byte-enabled writes.
    always @(posedge clk) begin
        mem_rdata <= sram[mem_addr[9:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_w_en[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [15:0] daddr;
        logic [31:0] dwdata;
        logic        clr;
        logic        eig, edg;
        logic [3:0]  emwen;
        logic [15:0] emaddr;
        logic [31:0] emwdata;
        logic        eirv, edrv;
        logic [31:0] eird, edrd;
        logic        eist, edst;
        logic [15:0] ecnt;
        logic [31:0] ew128;
    } vec_t;

    localparam logic [31:0] A5 = 32'hA5A5A5A5;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] FA = 32'hFFFFABCD;

    vec_t tbl [23];

    task automatic chk(input string nm, input int row, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, row, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_w_en = 0; d_addr = 0; d_wdata = 0; cnt_clr = 0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) sram[k] = 32'h0;
        sram[4]   = 32'h00000013;
        sram[8]   = 32'h11112222;
        sram[64]  = 32'hFFFFFFFF;
        sram[128] = A5;

        //         ireq iaddr     dreq dwen   daddr     dwdata         clr  ig dg mwen   maddr     mwdata         irv drv ird           drd  ist dst cnt    w128
        tbl[0]  = '{1, 16'h0010, 0, 4'h0, 16'h0000, 32'h0,         0,   1, 0, 4'h0, 16'h0010, 32'h0,         0, 0, 32'h0,        32'h0, 0, 0, 16'd0,  A5};
        tbl[1]  = '{0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,         0,   0, 0, 4'h0, 16'h0000, 32'h0,         1, 0, 32'h13,       32'h0, 0, 0, 16'd0,  A5};
        tbl[2]  = '{0, 16'h0000, 1, 4'h3, 16'h0100, 32'h1234ABCD,  0,   0, 1, 4'h3, 16'h0100, 32'h1234ABCD,  0, 0, 32'h0,        32'h0, 0, 0, 16'd0,  A5};
        tbl[3]  = '{0, 16'h0000, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 0, 32'h0,        32'h0, 0, 0, 16'd0,  A5};
        tbl[4]  = '{0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,         0,   0, 0, 4'h0, 16'h0000, 32'h0,         0, 1, 32'h0,        FA,    0, 0, 16'd0,  A5};
        tbl[5]  = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 0, 32'h0,        32'h0, 1, 0, 16'd0,  A5};
        tbl[6]  = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 1, 32'h0,        FA,    1, 0, 16'd1,  A5};
        tbl[7]  = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 1, 32'h0,        FA,    1, 0, 16'd2,  A5};
        tbl[8]  = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   1, 0, 4'h0, 16'h0010, 32'h0,         0, 1, 32'h0,        FA,    0, 1, 16'd3,  A5};
        tbl[9]  = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         1, 0, 32'h13,       32'h0, 1, 0, 16'd4,  A5};
        tbl[10] = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 1, 32'h0,        FA,    1, 0, 16'd5,  A5};
        tbl[11] = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 1, 32'h0,        FA,    1, 0, 16'd6,  A5};
        tbl[12] = '{1, 16'h0010, 1, 4'h0, 16'h0100, 32'h0,         0,   1, 0, 4'h0, 16'h0010, 32'h0,         0, 1, 32'h0,        FA,    0, 1, 16'd7,  A5};
        tbl[13] = '{0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,         0,   0, 0, 4'h0, 16'h0000, 32'h0,         1, 0, 32'h13,       32'h0, 0, 0, 16'd8,  A5};
        tbl[14] = '{1, 16'h0020, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 0, 32'h0,        32'h0, 1, 0, 16'd8,  A5};
        tbl[15] = '{1, 16'h0020, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 1, 32'h0,        FA,    1, 0, 16'd9,  A5};
        tbl[16] = '{1, 16'h0020, 1, 4'h0, 16'h0100, 32'h0,         0,   0, 1, 4'h0, 16'h0100, 32'h0,         0, 1, 32'h0,        FA,    1, 0, 16'd10, A5};
        tbl[17] = '{1, 16'h0020, 1, 4'hF, 16'h0200, DB,            0,   1, 0, 4'h0, 16'h0020, 32'h0,         0, 1, 32'h0,        FA,    0, 1, 16'd11, A5};
        tbl[18] = '{0, 16'h0000, 1, 4'hF, 16'h0200, DB,            0,   0, 1, 4'hF, 16'h0200, DB,            1, 0, 32'h11112222, 32'h0, 0, 0, 16'd12, A5};
        tbl[19] = '{0, 16'h0000, 1, 4'h0, 16'h0200, 32'h0,         0,   0, 1, 4'h0, 16'h0200, 32'h0,         0, 0, 32'h0,        32'h0, 0, 0, 16'd12, DB};
        tbl[20] = '{0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,         0,   0, 0, 4'h0, 16'h0000, 32'h0,         0, 1, 32'h0,        DB,    0, 0, 16'd12, DB};
        tbl[21] = '{0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,         1,   0, 0, 4'h0, 16'h0000, 32'h0,         0, 0, 32'h0,        32'h0, 0, 0, 16'd12, DB};
        tbl[22] = '{0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,         0,   0, 0, 4'h0, 16'h0000, 32'h0,         0, 0, 32'h0,        32'h0, 0, 0, 16'd0,  DB};

        // Requests held during reset must not be granted or reach the SRAM.
        idle_inputs();
        rst = 1; i_req = 1; d_req = 1; d_w_en = 4'hF; d_addr = 16'h0200; d_wdata = DB;
        #3;
        chk("rst_i_gnt", -1, 64'(i_gnt), 64'd0);
        chk("rst_d_gnt", -1, 64'(d_gnt), 64'd0);
        chk("rst_mem_w_en", -1, 64'(mem_w_en), 64'd0);
        chk("rst_mem_addr", -1, 64'(mem_addr), 64'd0);
        chk("rst_rvalid", -1, {62'd0, i_rvalid, d_rvalid}, 64'd0);
        chk("rst_cnt", -1, 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 0;

        for (int r = 0; r < 23; r++) begin
            @(negedge clk);
            i_req = tbl[r].ireq; i_addr = tbl[r].iaddr; d_req = tbl[r].dreq; d_w_en = tbl[r].dwen;
            d_addr = tbl[r].daddr; d_wdata = tbl[r].dwdata; cnt_clr = tbl[r].clr;
            #1;
            chk("i_gnt", r, 64'(i_gnt), 64'(tbl[r].eig));
            chk("d_gnt", r, 64'(d_gnt), 64'(tbl[r].edg));
            chk("mem_w_en", r, 64'(mem_w_en), 64'(tbl[r].emwen));
            chk("mem_addr", r, 64'(mem_addr), 64'(tbl[r].emaddr));
            chk("mem_wdata", r, 64'(mem_wdata), 64'(tbl[r].emwdata));
            chk("i_rvalid", r, 64'(i_rvalid), 64'(tbl[r].eirv));
            chk("d_rvalid", r, 64'(d_rvalid), 64'(tbl[r].edrv));
            chk("i_rdata", r, 64'(i_rdata), 64'(tbl[r].eird));
            chk("d_rdata", r, 64'(d_rdata), 64'(tbl[r].edrd));
            chk("i_stall", r, 64'(i_stall), 64'(tbl[r].eist));
            chk("d_stall", r, 64'(d_stall), 64'(tbl[r].edst));
            chk("conflict_cnt", r, 64'(conflict_cnt), 64'(tbl[r].ecnt));
            chk("sram_0x200", r, 64'(sram[128]), 64'(tbl[r].ew128));
        end

        // Reset asserted between a D read's accepting edge and its return.
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010; d_req = 1; d_w_en = 0; d_addr = 16'h0100; d_wdata = 0; cnt_clr = 0;
        #1;
        chk("mr_d_gnt", 100, 64'(d_gnt), 64'd1);
        @(posedge clk);
        #1;
        chk("mr_d_rvalid_pre", 100, 64'(d_rvalid), 64'd1);
        chk("mr_cnt_pre", 100, 64'(conflict_cnt), 64'd1);
        rst = 1;
        #1;
        chk("mr_d_rvalid", 100, 64'(d_rvalid), 64'd0);
        chk("mr_d_rdata", 100, 64'(d_rdata), 64'd0);
        chk("mr_gnts", 100, {62'd0, i_gnt, d_gnt}, 64'd0);
        chk("mr_cnt", 100, 64'(conflict_cnt), 64'd0);
        chk("mr_mem_addr", 100, 64'(mem_addr), 64'd0);
        @(negedge clk);
        d_req = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("mr_first_i_gnt", 101, 64'(i_gnt), 64'd1);
        chk("mr_first_addr", 101, 64'(mem_addr), 64'h10);
        chk("mr_no_d_rvalid", 101, 64'(d_rvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("mr_i_rvalid", 101, 64'(i_rvalid), 64'd1);
        chk("mr_i_rdata", 101, 64'(i_rdata), 64'h13);

        // Saturation in the 2-bit counter instance, then clear against a conflict.
        @(negedge clk);
        i_req = 1; d_req = 1;
        repeat (5) @(negedge clk);
        #1;
        chk("sat_cnt2", 102, 64'(s_conflict_cnt), 64'd3);
        chk("sat_cnt16", 102, 64'(conflict_cnt), 64'd5);
        cnt_clr = 1;
        @(negedge clk);
        #1;
        chk("clr_cnt2", 103, 64'(s_conflict_cnt), 64'd0);
        chk("clr_cnt16", 103, 64'(conflict_cnt), 64'd0);
        cnt_clr = 0;
        @(negedge clk);
        #1;
        chk("post_clr_cnt2", 104, 64'(s_conflict_cnt), 64'd1);
        idle_inputs();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
